fifo_sync_param: RTL and testbench
==================================

FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 SHALL have parameter WIDTH, default 12: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: number of entries, a power of two, at least 2.
REQ-003 SHALL have parameter AF_DEF, default 6: reset value of the almost-full threshold.
REQ-004 SHALL have parameter AE_DEF, default 1: reset value of the almost-empty threshold.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port push, input, 1: write request.
REQ-008 SHALL have port data_in, input, WIDTH: write data.
REQ-009 SHALL have port pop, input, 1: read request.
REQ-010 SHALL have port data_out, output, WIDTH: registered read data.
REQ-011 SHALL have port rd_valid, output, 1: data_out holds a newly popped word this cycle.
REQ-012 SHALL have port cfg_load, input, 1: latch cfg_af and cfg_ae on this edge.
REQ-013 SHALL have ports cfg_af and cfg_ae, input, CW each: new threshold values.
REQ-014 SHALL have port count, output, CW: current occupancy.
REQ-015 SHALL have ports full, empty, alm_full and alm_empty, output, 1 each: status flags.
REQ-016 SHALL have ports overflow and underflow, output, 1 each: sticky error flags.
REQ-017 SHALL have port err_clr, input, 1: clears the sticky error flags.
REQ-018 SHALL size CW as clog2(DEPTH)+1.

Function
REQ-019 SHALL accept a push iff push=1 and full=0; an accepted push writes data_in at wr_ptr, and wr_ptr wraps modulo DEPTH.
REQ-020 SHALL accept a pop iff pop=1 and empty=0; data_out updates one cycle after acceptance, rd_valid=1 for that cycle, and rd_ptr wraps modulo DEPTH.
REQ-021 SHALL store all WIDTH-bit values, including zero.
REQ-022 SHALL leave count unchanged when push and pop are both accepted in the same cycle; it SHALL be +1 for a push only and -1 for a pop only.
REQ-023 SHALL, when full and both push and pop are asserted, accept the pop, reject the push, and set overflow.
REQ-024 SHALL, when empty and both push and pop are asserted, accept the push, reject the pop, and set underflow; there is no fall-through.
REQ-025 SHALL set overflow on a rejected push and set underflow on a rejected pop; both stay set until err_clr or reset.
REQ-026 SHALL give a same-cycle set event priority over err_clr.
REQ-027 SHALL hold data_out at its last value when no pop is accepted.
REQ-028 SHALL derive all flags combinationally from the registered count:
- full = (count == DEPTH)
- empty = (count == 0)
- alm_full = (count >= af_thr)
- alm_empty = (count <= ae_thr)
REQ-029 SHALL load af_thr and ae_thr from cfg_af and cfg_ae on any cycle with cfg_load=1, and SHALL NOT disturb data or pointers.
REQ-030 SHALL give new thresholds effect on the flags from the next cycle.
REQ-031 SHALL clamp loaded threshold values greater than DEPTH to DEPTH.

Reset
REQ-032 SHALL, on reset=1, immediately clear wr_ptr, rd_ptr, count, rd_valid, overflow, underflow and data_out to 0.
REQ-033 SHALL set af_thr=AF_DEF and ae_thr=AE_DEF on reset, so that empty=1, full=0, alm_empty=1 and alm_full=0.
REQ-034 SHALL discard all stored data and any in-flight read when reset is asserted mid-operation; RAM contents need not be cleared.
REQ-035 SHALL ignore push and pop in the first cycle after reset deassertion only if they are synchronised externally; no internal gating.

Structure
REQ-036 SHALL place the default constants (WIDTH, DEPTH, AF_DEF, AE_DEF) and the CW width function in shared package fifo_pkg.
REQ-037 SHALL implement storage in sub-module dpram_param: one write port and one registered read port, parametrised by WIDTH and DEPTH, with no reset on the array.
REQ-038 SHALL keep pointer, count, flag and threshold logic in fifo_sync_param.

Verification (WIDTH=12, DEPTH=8)
REQ-039 SHALL cover fill and drain: push 8 words 0x001..0x008 -> full=1 and count=8; pop 8 -> data_out 0x001..0x008 in order, each one cycle after pop, then empty=1.
REQ-040 SHALL cover wrap-around with simultaneous push and pop: fill 5 words, then 10 cycles of push+pop -> count stays 5, order preserved across the pointer wrap, no error flags.
REQ-041 SHALL cover errors and clear: push while full -> overflow=1 and the word is dropped; pop while empty -> underflow=1 and rd_valid=0; err_clr -> both flags 0.
REQ-042 SHALL cover thresholds: cfg_load with cfg_af=3 and cfg_ae=0 -> alm_full=1 at count 3 and alm_empty=1 only at count 0; cfg_af=15 -> clamped to 8.
REQ-043 SHALL cover reset mid-operation: assert reset at count=4 during a pop -> count=0, empty=1, data_out=0 and rd_valid=0 asynchronously.
REQ-044 SHALL cover zero data: push 0x000 -> accepted, count increments, and 0x000 is read back.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the synchronous FIFO.
// Imported by the FIFO top and its storage sub-module.
package fifo_pkg;

    localparam int D_WIDTH  = 12;
    localparam int D_DEPTH  = 8;
    localparam int D_AF_DEF = 6;
    localparam int D_AE_DEF = 1;

    // Occupancy width: must hold 0..DEPTH inclusive.
    function automatic int cw_f(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dpram_param.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module dpram_param
    import fifo_pkg::*;
#(
    parameter int WIDTH = D_WIDTH,
    parameter int DEPTH = D_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store one word per accepted write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered, holds last word when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with programmable almost-full/empty thresholds
// and sticky overflow/underflow error flags.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH  = D_WIDTH,
    parameter int DEPTH  = D_DEPTH,
    parameter int AF_DEF = D_AF_DEF,
    parameter int AE_DEF = D_AE_DEF,
    localparam int CW = cw_f(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid,
    input  logic             cfg_load,
    input  logic [CW-1:0]    cfg_af,
    input  logic [CW-1:0]    cfg_ae,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             alm_full,
    output logic             alm_empty,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] af_thr;
    logic [CW-1:0] ae_thr;
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [CW-1:0] clamp_thr(input logic [CW-1:0] v);
        return (v > FULL_C) ? FULL_C : v;
    endfunction

    assign full      = (count == FULL_C);
    assign empty     = (count == '0);
    assign alm_full  = (count >= af_thr);
    assign alm_empty = (count <= ae_thr);

    // Full wins over push, empty wins over pop: no fall-through.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    dpram_param #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (push_ok),
        .wr_addr(wr_ptr),
        .wr_data(data_in),
        .rd_en  (pop_ok),
        .rd_addr(rd_ptr),
        .rd_data(data_out)
    );

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy tracks net accepted pushes minus pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // rd_valid marks the cycle data_out carries a fresh word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_ok;
        end
    end

    // Sticky error flags; a new error beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push & full)  overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
            if (pop & empty)  underflow <= 1'b1;
            else if (err_clr) underflow <= 1'b0;
        end
    end

    // Threshold registers, clamped so they never exceed DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            af_thr <= CW'(AF_DEF);
            ae_thr <= CW'(AE_DEF);
        end else if (cfg_load) begin
            af_thr <= clamp_thr(cfg_af);
            ae_thr <= clamp_thr(cfg_ae);
        end
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param with a queue scoreboard
// and a small occupancy/flag reference model.
module tb_fifo_sync_param;

    localparam int W  = 12;
    localparam int D  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic [W-1:0]  data_in;
    logic          pop;
    logic [W-1:0]  data_out;
    logic          rd_valid;
    logic          cfg_load;
    logic [CW-1:0] cfg_af;
    logic [CW-1:0] cfg_ae;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          alm_full;
    logic          alm_empty;
    logic          overflow;
    logic          underflow;
    logic          err_clr;

    int passed = 0;
    int total  = 0;

    logic [W-1:0] sb[$];
    int           mc;
    int           af_m;
    int           ae_m;
    logic         exp_ov;
    logic         exp_un;
    logic [W-1:0] exp_dout;

    always #5 clk = ~clk;

    fifo_sync_param #(
        .WIDTH(W), .DEPTH(D), .AF_DEF(6), .AE_DEF(1)
    ) dut (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in),
        .pop(pop), .data_out(data_out), .rd_valid(rd_valid),
        .cfg_load(cfg_load), .cfg_af(cfg_af), .cfg_ae(cfg_ae),
        .count(count), .full(full), .empty(empty),
        .alm_full(alm_full), .alm_empty(alm_empty),
        .overflow(overflow), .underflow(underflow),
        .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input bit qa);
        chk("count", 32'(count), 32'(mc));
        chk("full", 32'(full), 32'(mc == D));
        chk("empty", 32'(empty), 32'(mc == 0));
        chk("alm_full", 32'(alm_full), 32'(mc >= af_m));
        chk("alm_empty", 32'(alm_empty), 32'(mc <= ae_m));
        chk("overflow", 32'(overflow), 32'(exp_ov));
        chk("underflow", 32'(underflow), 32'(exp_un));
        chk("rd_valid", 32'(rd_valid), 32'(qa));
        chk("data_out", 32'(data_out), 32'(exp_dout));
    endtask

    function automatic int clampi(input int v);
        return (v > D) ? D : v;
    endfunction

    task automatic cycle(input bit p, input logic [W-1:0] d,
                         input bit q, input bit clr = 1'b0);
        bit pa, qa, ovs, uns;
        push = p; data_in = d; pop = q; err_clr = clr;
        pa  = p && (mc < D);
        qa  = q && (mc > 0);
        ovs = p && (mc == D);
        uns = q && (mc == 0);
        if (qa) exp_dout = sb.pop_front();
        if (pa) sb.push_back(d);
        exp_ov = ovs ? 1'b1 : (clr ? 1'b0 : exp_ov);
        exp_un = uns ? 1'b1 : (clr ? 1'b0 : exp_un);
        mc = mc + int'(pa) - int'(qa);
        if (cfg_load) begin
            af_m = clampi(int'(cfg_af));
            ae_m = clampi(int'(cfg_ae));
        end
        @(posedge clk); #1;
        push = 0; pop = 0; err_clr = 0; cfg_load = 0;
        check_all(qa);
    endtask

    task automatic load_cfg(input int af, input int ae);
        cfg_af = CW'(af); cfg_ae = CW'(ae); cfg_load = 1'b1;
        cycle(1'b0, '0, 1'b0);
    endtask

    initial begin
        reset = 1; push = 0; pop = 0; data_in = '0; err_clr = 0;
        cfg_load = 0; cfg_af = '0; cfg_ae = '0;
        mc = 0; af_m = 6; ae_m = 1; exp_ov = 0; exp_un = 0;
        exp_dout = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all(1'b0);
        reset = 0;

        // Fill and drain in order.
        for (int i = 1; i <= 8; i++) cycle(1'b1, W'(i), 1'b0);
        for (int i = 1; i <= 8; i++) cycle(1'b0, '0, 1'b1);

        // Wrap with simultaneous push and pop.
        for (int i = 0; i < 5; i++) cycle(1'b1, W'(12'h010 + i), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, W'(12'h020 + i), 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);

        // Overflow, full push+pop, clear priority, drain.
        for (int i = 0; i < 8; i++) cycle(1'b1, W'(12'h100 + i), 1'b0);
        cycle(1'b1, 12'hABC, 1'b0);
        cycle(1'b1, 12'hABD, 1'b1);
        cycle(1'b1, 12'hABE, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);

        // Underflow, empty push+pop, clear.
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 12'h3C3, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Thresholds and clamp.
        load_cfg(3, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, W'(12'h200 + i), 1'b0);
        load_cfg(15, 0);
        for (int i = 0; i < 4; i++) cycle(1'b1, W'(12'h210 + i), 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);

        // Zero data word.
        cycle(1'b1, 12'h000, 1'b0);
        cycle(1'b1, 12'hFFF, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);

        // Reset in the middle of a pop at count 4.
        for (int i = 0; i < 5; i++) cycle(1'b1, W'(12'h300 + i), 1'b0);
        cycle(1'b0, '0, 1'b1);
        pop = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_dout", 32'(data_out), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        pop = 1'b0;
        sb.delete();
        mc = 0; af_m = 6; ae_m = 1; exp_ov = 0; exp_un = 0;
        exp_dout = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        check_all(1'b0);
        cycle(1'b1, 12'h5A5, 1'b0);
        cycle(1'b0, '0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
